decode_stage: RTL and testbench

- RV32I decode stage directly downstream of the instruction fetch stage.
- Accepts the fetched word and its word-address PC over a valid/ready handshake and classifies the instruction format.
- Extracts register indices and the sign-extended immediate, and registers one decoded bundle for execute.
- Resolves JAL early: issues a redirect (pc_sel/imm_addr-style) back to fetch and squashes wrong-path words already in flight.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage_imm_gen.sv | 23 ++
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, format codes, decode FSM states, fetch PC-select codes.
// Also provides the opcode-to-format helper used by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  function automatic logic [2:0] opcode_fmt(input logic [6:0] op);
    logic [2:0] f;
    case (op)
      OP_R:                                 f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  f = FMT_I;
      OP_STORE:                             f = FMT_S;
      OP_BRANCH:                            f = FMT_B;
      OP_LUI, OP_AUIPC:                     f = FMT_U;
      OP_JAL:                               f = FMT_J;
      default:                              f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode, decode-to-execute and redirect signals of the decode stage.
// slave = decode stage side, master = surrounding fetch/execute environment.
interface decode_stage_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_ready;
  logic                  flush;
  logic                  id_valid;
  logic                  id_ready;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_instr;
  logic [2:0]            id_fmt;
  logic [4:0]            id_rd;
  logic [4:0]            id_rs1;
  logic [4:0]            id_rs2;
  logic [2:0]            id_funct3;
  logic [6:0]            id_funct7;
  logic [31:0]           id_imm;
  logic                  id_illegal;
  logic                  redir_valid;
  logic [1:0]            redir_pc_sel;
  logic [ADDR_WIDTH-1:0] redir_addr;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_fmt, id_rd, id_rs1, id_rs2,
           id_funct3, id_funct7, id_imm, id_illegal, redir_valid, redir_pc_sel, redir_addr
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_fmt, id_rd, id_rs1, id_rs2,
           id_funct3, id_funct7, id_imm, id_illegal, redir_valid, redir_pc_sel, redir_addr
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: instr[31:7] + format code -> sign-extended immediate.
// Zero for R-format and unknown formats.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [2:0]  fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: 1-cycle registered decode, early JAL redirect with wrong-path drop.
// Optional DECODE_PERF_CNT_EN adds accepted-instruction and illegal-instruction counters.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int DROP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  decode_stage_if.slave bus
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0] perf_instr_cnt,
  output logic [15:0] perf_illegal_cnt
`endif
);

  logic [0:0]            state;
  logic [2:0]            drop_cnt;
  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_instr;
  logic [2:0]            id_fmt;
  logic [4:0]            id_rd, id_rs1, id_rs2;
  logic [31:0]           id_imm;
  logic                  id_illegal;
  logic                  redir_valid;
  logic [ADDR_WIDTH-1:0] redir_addr;

  logic [2:0]            fmt;
  logic [31:0]           imm;
  logic [4:0]            rd, rs1, rs2;
  logic                  is_jal, jal_ok, illegal, if_ready, accept;
  logic [ADDR_WIDTH-1:0] target;

  assign fmt = opcode_fmt(bus.if_instr[6:0]);

  imm_gen u_imm_gen (
    .instr (bus.if_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  // A JAL with imm[1] set would land mid-word: trap it instead of redirecting.
  assign is_jal  = (fmt == FMT_J);
  assign jal_ok  = is_jal && !imm[1];
  assign illegal = (fmt == FMT_NONE) || (is_jal && imm[1]);
  assign target  = bus.if_pc + imm[ADDR_WIDTH+1:2];

  always_comb begin
    rd  = '0;
    rs1 = '0;
    rs2 = '0;
    case (fmt)
      FMT_R:        begin rd = bus.if_instr[11:7]; rs1 = bus.if_instr[19:15]; rs2 = bus.if_instr[24:20]; end
      FMT_I:        begin rd = bus.if_instr[11:7]; rs1 = bus.if_instr[19:15]; end
      FMT_S, FMT_B: begin rs1 = bus.if_instr[19:15]; rs2 = bus.if_instr[24:20]; end
      FMT_U, FMT_J: rd = bus.if_instr[11:7];
      default:      ;
    endcase
  end

  assign if_ready = (state == ST_DROP) || !id_valid || bus.id_ready;
  assign accept   = bus.if_valid && if_ready && (state == ST_RUN) && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      drop_cnt    <= '0;
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= '0;
      id_fmt      <= '0;
      id_rd       <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_imm      <= '0;
      id_illegal  <= 1'b0;
      redir_valid <= 1'b0;
      redir_addr  <= '0;
    end else if (bus.flush) begin
      state       <= ST_RUN;
      drop_cnt    <= '0;
      id_valid    <= 1'b0;
      redir_valid <= 1'b0;
    end else begin
      redir_valid <= accept && jal_ok;
      redir_addr  <= (accept && jal_ok) ? target : '0;
      if (accept) begin
        id_valid   <= 1'b1;
        id_pc      <= bus.if_pc;
        id_instr   <= bus.if_instr;
        id_fmt     <= fmt;
        id_rd      <= rd;
        id_rs1     <= rs1;
        id_rs2     <= rs2;
        id_imm     <= imm;
        id_illegal <= illegal;
      end else if (bus.id_ready) begin
        id_valid <= 1'b0;
      end
      if (accept && jal_ok) begin
        state    <= ST_DROP;
        drop_cnt <= 3'(DROP_CYCLES);
      end else if (state == ST_DROP && bus.if_valid) begin
        drop_cnt <= drop_cnt - 3'd1;
        if (drop_cnt == 3'd1) state <= ST_RUN;
      end
    end
  end

  assign bus.if_ready     = if_ready;
  assign bus.id_valid     = id_valid;
  assign bus.id_pc        = id_pc;
  assign bus.id_instr     = id_instr;
  assign bus.id_fmt       = id_fmt;
  assign bus.id_rd        = id_rd;
  assign bus.id_rs1       = id_rs1;
  assign bus.id_rs2       = id_rs2;
  assign bus.id_funct3    = id_instr[14:12];
  assign bus.id_funct7    = id_instr[31:25];
  assign bus.id_imm       = id_imm;
  assign bus.id_illegal   = id_illegal;
  assign bus.redir_valid  = redir_valid;
  assign bus.redir_pc_sel = redir_valid ? PC_SEL_IMM : PC_SEL_SEQ;
  assign bus.redir_addr   = redir_addr;

`ifdef DECODE_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_cnt   <= '0;
      perf_illegal_cnt <= '0;
    end else if (accept) begin
      perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (illegal && perf_illegal_cnt != 16'hFFFF)
        perf_illegal_cnt <= perf_illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode, backpressure, JAL redirect/drop,
// flush, illegal handling and asynchronous reset (perf counters when DECODE_PERF_CNT_EN).
module tb_decode_stage;
  import riscv_pkg::*;

  localparam logic [31:0] I_ADDI = 32'hFFD08293;  // addi x5,x1,-3
  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_SW   = 32'h0020A423;  // sw   x2,8(x1)
  localparam logic [31:0] I_LUI  = 32'h123453B7;  // lui  x7,0x12345
  localparam logic [31:0] I_JAL  = 32'h010000EF;  // jal  x1,+16
  localparam logic [31:0] I_JALM = 32'h002000EF;  // jal  x1,+2 (misaligned)
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  decode_stage_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_instr_cnt;
  logic [15:0] perf_illegal_cnt;
`endif

  decode_stage #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DROP_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_instr_cnt   (perf_instr_cnt),
    .perf_illegal_cnt (perf_illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [10:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic idle();
    bus.if_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    #3;
    check("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst_redir_valid", {31'b0, bus.redir_valid}, 32'd0);
    check("rst_id_imm", bus.id_imm, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic I-format decode
    present(I_ADDI, 11'd4);
    tick();
    idle();
    check("addi_valid", {31'b0, bus.id_valid}, 32'd1);
    check("addi_pc", {21'b0, bus.id_pc}, 32'd4);
    check("addi_fmt", {29'b0, bus.id_fmt}, {29'b0, FMT_I});
    check("addi_rd", {27'b0, bus.id_rd}, 32'd5);
    check("addi_rs1", {27'b0, bus.id_rs1}, 32'd1);
    check("addi_rs2", {27'b0, bus.id_rs2}, 32'd0);
    check("addi_imm", bus.id_imm, 32'hFFFFFFFD);
    check("addi_illegal", {31'b0, bus.id_illegal}, 32'd0);
    tick();
    check("addi_drain", {31'b0, bus.id_valid}, 32'd0);

    // Backpressure: bundle must hold while execute stalls
    bus.id_ready = 1'b0;
    present(I_ADD, 11'd10);
    tick();
    check("bp_first_valid", {31'b0, bus.id_valid}, 32'd1);
    check("bp_add_rs2", {27'b0, bus.id_rs2}, 32'd2);
    present(I_SW, 11'd11);
    #1;
    check("bp_if_ready_low", {31'b0, bus.if_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", {31'b0, bus.id_valid}, 32'd1);
      check("bp_hold_pc", {21'b0, bus.id_pc}, 32'd10);
      check("bp_hold_instr", bus.id_instr, I_ADD);
    end
    bus.id_ready = 1'b1;
    #1;
    check("bp_if_ready_high", {31'b0, bus.if_ready}, 32'd1);
    tick();
    check("sw_valid", {31'b0, bus.id_valid}, 32'd1);
    check("sw_pc", {21'b0, bus.id_pc}, 32'd11);
    check("sw_fmt", {29'b0, bus.id_fmt}, {29'b0, FMT_S});
    check("sw_rd", {27'b0, bus.id_rd}, 32'd0);
    check("sw_rs1", {27'b0, bus.id_rs1}, 32'd1);
    check("sw_imm", bus.id_imm, 32'd8);
    check("sw_funct3", {29'b0, bus.id_funct3}, 32'd2);
    present(I_LUI, 11'd12);
    tick();
    check("lui_pc", {21'b0, bus.id_pc}, 32'd12);
    check("lui_fmt", {29'b0, bus.id_fmt}, {29'b0, FMT_U});
    check("lui_rd", {27'b0, bus.id_rd}, 32'd7);
    check("lui_rs1", {27'b0, bus.id_rs1}, 32'd0);
    check("lui_imm", bus.id_imm, 32'h12345000);
    idle();
    tick();
    check("bp_drain", {31'b0, bus.id_valid}, 32'd0);

    // JAL at 2046 + 16 bytes wraps to word 2; two wrong-path words dropped
    present(I_JAL, 11'd2046);
    tick();
    check("jal_valid", {31'b0, bus.id_valid}, 32'd1);
    check("jal_fmt", {29'b0, bus.id_fmt}, {29'b0, FMT_J});
    check("jal_imm", bus.id_imm, 32'd16);
    check("jal_redir_valid", {31'b0, bus.redir_valid}, 32'd1);
    check("jal_redir_sel", {30'b0, bus.redir_pc_sel}, 32'd1);
    check("jal_redir_addr", {21'b0, bus.redir_addr}, 32'd2);
    present(I_ADDI, 11'd2047);
    #1;
    check("drop_if_ready", {31'b0, bus.if_ready}, 32'd1);
    tick();
    check("drop1_valid", {31'b0, bus.id_valid}, 32'd0);
    check("redir_one_cycle", {31'b0, bus.redir_valid}, 32'd0);
    check("redir_sel_clear", {30'b0, bus.redir_pc_sel}, 32'd0);
    idle();
    tick();
    present(I_ADDI, 11'd0);
    tick();
    check("drop2_valid", {31'b0, bus.id_valid}, 32'd0);
    present(I_ADD, 11'd2);
    tick();
    idle();
    check("target_valid", {31'b0, bus.id_valid}, 32'd1);
    check("target_pc", {21'b0, bus.id_pc}, 32'd2);
    tick();

    // Flush in the same cycle a JAL is presented
    present(I_JAL, 11'd100);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_no_valid", {31'b0, bus.id_valid}, 32'd0);
    check("flush_no_redir", {31'b0, bus.redir_valid}, 32'd0);
    present(I_ADDI, 11'd101);
    tick();
    idle();
    check("post_flush_valid", {31'b0, bus.id_valid}, 32'd1);
    check("post_flush_pc", {21'b0, bus.id_pc}, 32'd101);

    // Illegal opcode and misaligned JAL
    present(I_BAD, 11'd20);
    tick();
    check("bad_valid", {31'b0, bus.id_valid}, 32'd1);
    check("bad_illegal", {31'b0, bus.id_illegal}, 32'd1);
    check("bad_fmt", {29'b0, bus.id_fmt}, {29'b0, FMT_NONE});
    check("bad_imm", bus.id_imm, 32'd0);
    present(I_JALM, 11'd21);
    tick();
    check("jalm_illegal", {31'b0, bus.id_illegal}, 32'd1);
    check("jalm_no_redir", {31'b0, bus.redir_valid}, 32'd0);
    present(I_ADDI, 11'd22);
    tick();
    idle();
    check("after_jalm_pc", {21'b0, bus.id_pc}, 32'd22);
    check("after_jalm_legal", {31'b0, bus.id_illegal}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    check("perf_instr", perf_instr_cnt, 32'd10);
    check("perf_illegal", {16'b0, perf_illegal_cnt}, 32'd2);
`endif
    tick();

    // Asynchronous reset in the middle of a DROP window
    present(I_JAL, 11'd30);
    tick();
    idle();
    check("jal2_redir_addr", {21'b0, bus.redir_addr}, 32'd34);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    check("arst_redir_valid", {31'b0, bus.redir_valid}, 32'd0);
    check("arst_redir_addr", {21'b0, bus.redir_addr}, 32'd0);
    check("arst_id_pc", {21'b0, bus.id_pc}, 32'd0);
    check("arst_id_instr", bus.id_instr, 32'd0);
    rst_n = 1'b1;
    present(I_ADDI, 11'd40);
    tick();
    idle();
    check("post_rst_valid", {31'b0, bus.id_valid}, 32'd1);
    check("post_rst_pc", {21'b0, bus.id_pc}, 32'd40);
    check("post_rst_imm", bus.id_imm, 32'hFFFFFFFD);
`ifdef DECODE_PERF_CNT_EN
    check("perf_instr_rst", perf_instr_cnt, 32'd1);
    check("perf_illegal_rst", {16'b0, perf_illegal_cnt}, 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
